// File: rtl/rst_pkg.sv
// rst_pkg: sequencer state encoding and default cycle counts shared by the reset logic
package rst_pkg;
    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_PERIPH    = 3'd3,
        ST_RUN       = 3'd4,
        ST_SOFT      = 3'd5
    } state_t;
    localparam int DEF_SYNC_STAGES        = 2;
    localparam int DEF_LOCK_STABLE_CYCLES = 1024;
    localparam int DEF_CORE_DELAY_CYCLES  = 16;
    localparam int DEF_SOFT_HOLD_CYCLES   = 16;
endpackage

// File: rtl/sync_bit.sv
// sync_bit: STAGES-deep single-bit synchronizer with sync clear (clock, reset, d async in, q synced out)
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] chain;
    always_ff @(posedge clock)
        chain <= reset ? '0 : {chain[STAGES-2:0], d};
    assign q = chain[STAGES-1];
endmodule

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: staged SoC reset from PLL lock (clock, reset, pll_locked, soft_reset_req in; periph_reset, core_reset, ready out)
module pll_reset_sequencer
    import rst_pkg::*;
#(
    parameter int SYNC_STAGES        = DEF_SYNC_STAGES,
    parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
    parameter int CORE_DELAY_CYCLES  = DEF_CORE_DELAY_CYCLES,
    parameter int SOFT_HOLD_CYCLES   = DEF_SOFT_HOLD_CYCLES
) (
    input  logic clock,
    input  logic reset,
    input  logic pll_locked,
    input  logic soft_reset_req,
    output logic periph_reset,
    output logic core_reset,
    output logic ready
);
    localparam int MAX_A = LOCK_STABLE_CYCLES > CORE_DELAY_CYCLES ? LOCK_STABLE_CYCLES : CORE_DELAY_CYCLES;
    localparam int MAX_C = MAX_A > SOFT_HOLD_CYCLES ? MAX_A : SOFT_HOLD_CYCLES;
    localparam int CW    = $clog2(MAX_C + 1);
    localparam logic [CW-1:0] LOCK_END = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0] CORE_END = CW'(CORE_DELAY_CYCLES - 1);
    localparam logic [CW-1:0] SOFT_END = CW'(SOFT_HOLD_CYCLES - 1);

    logic          lock_sync;
    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          locked_state;

    sync_bit #(.STAGES(SYNC_STAGES)) u_lock_sync (
        .clock (clock),
        .reset (reset),
        .d     (pll_locked),
        .q     (lock_sync)
    );

    // lock loss only matters once the sequencer has seen lock at least once
    assign locked_state = state inside {ST_STABLE, ST_PERIPH, ST_RUN, ST_SOFT};

    always_comb begin
        state_n = state;
        case (state)
            ST_RESET:     state_n = ST_WAIT_LOCK;
            ST_WAIT_LOCK: state_n = lock_sync ? ST_STABLE : ST_WAIT_LOCK;
            ST_STABLE:    state_n = cnt == LOCK_END ? ST_PERIPH : ST_STABLE;
            ST_PERIPH:    state_n = cnt == CORE_END ? ST_RUN : ST_PERIPH;
            ST_RUN:       state_n = soft_reset_req ? ST_SOFT : ST_RUN;
            ST_SOFT:      state_n = cnt == SOFT_END ? ST_RUN : ST_SOFT;
            default:      state_n = ST_RESET;
        endcase
        if (locked_state && !lock_sync)
            state_n = ST_WAIT_LOCK;
        cnt_n = state_n != state ? '0 : cnt + CW'(locked_state && state != ST_RUN);
    end

    // outputs decode the next state so they change on the same edge as the state register
    always_ff @(posedge clock) begin
        state        <= reset ? ST_RESET : state_n;
        cnt          <= reset ? '0 : cnt_n;
        periph_reset <= reset ? 1'b1 : state_n inside {ST_RESET, ST_WAIT_LOCK, ST_STABLE};
        core_reset   <= reset ? 1'b1 : state_n != ST_RUN;
        ready        <= reset ? 1'b0 : state_n == ST_RUN;
    end
endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer: directed self-checking bench for the staged PLL reset sequencer
module tb_pll_reset_sequencer;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic pll_locked = 1'b1;
    logic soft_reset_req = 1'b0;
    logic periph_reset, core_reset, ready;
    int compared = 0;
    int mismatched = 0;

    pll_reset_sequencer #(
        .SYNC_STAGES        (2),
        .LOCK_STABLE_CYCLES (8),
        .CORE_DELAY_CYCLES  (4),
        .SOFT_HOLD_CYCLES   (4)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .pll_locked     (pll_locked),
        .soft_reset_req (soft_reset_req),
        .periph_reset   (periph_reset),
        .core_reset     (core_reset),
        .ready          (ready)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [2:0] exp);
        compared++;
        assert ({periph_reset, core_reset, ready} === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed p/c/r=%b expected p/c/r=%b at %0t", tag,
                   {periph_reset, core_reset, ready}, exp, $time);
        end
    endtask

    // walks edges 1..rel_run after the last reset/relock edge, checking the staged release
    task automatic run_seq(input string tag, input int rel_periph, input int rel_run);
        for (int e = 1; e <= rel_run; e++) begin
            tick();
            chk($sformatf("%s_e%0d", tag, e),
                {1'(e < rel_periph), 1'(e < rel_run), 1'(e >= rel_run)});
        end
    endtask

    initial begin
        tick();
        chk("reset_state", 3'b110);
        reset = 1'b0;
        run_seq("cold", 11, 15);

        tick();
        chk("run_hold", 3'b001);
        soft_reset_req = 1'b1;
        tick();
        soft_reset_req = 1'b0;
        chk("soft_j0", 3'b010);
        tick();
        chk("soft_j1", 3'b010);
        soft_reset_req = 1'b1;
        tick();
        soft_reset_req = 1'b0;
        chk("soft_j2_ignored", 3'b010);
        tick();
        chk("soft_j3", 3'b010);
        tick();
        chk("soft_j4_run", 3'b001);
        tick();
        chk("soft_no_extend", 3'b001);

        reset = 1'b1;
        tick();
        chk("reset_from_run", 3'b110);
        reset = 1'b0;
        for (int e = 1; e <= 8; e++) tick();
        pll_locked = 1'b0;
        tick();
        chk("glitch_e9", 3'b110);
        pll_locked = 1'b1;
        run_seq("glitch", 11, 15);

        pll_locked = 1'b0;
        tick();
        chk("loss_d1", 3'b001);
        tick();
        chk("loss_d2", 3'b001);
        tick();
        chk("loss_d3", 3'b110);
        pll_locked = 1'b1;
        run_seq("relock", 11, 15);

        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int e = 1; e <= 13; e++) tick();
        chk("periph_cnt2", 3'b010);
        reset = 1'b1;
        tick();
        chk("reset_in_periph", 3'b110);
        reset = 1'b0;
        run_seq("restart", 11, 15);

        reset = 1'b1;
        pll_locked = 1'b0;
        tick();
        reset = 1'b0;
        for (int e = 1; e <= 10000; e++) begin
            tick();
            chk($sformatf("nolock_e%0d", e), 3'b110);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Sits directly downstream of the iCE40 PLL wrapper.
- Runs on the PLL output clock and consumes the PLL's asynchronous lock flag.
- Produces glitch-free, synchronous, active-high reset outputs for the SoC, released in stages: peripherals/bus first, then the softcore.
- Re-asserts both resets on lock loss, and supports a CPU-requested soft reset of the core only.

Parameters:
- SYNC_STAGES, 2, flops in the lock synchronizer chain; must be >= 2.
- LOCK_STABLE_CYCLES, 1024, consecutive cycles of synchronized lock required before peripheral release; must be >= 1.
- CORE_DELAY_CYCLES, 16, cycles between peripheral release and core release; must be >= 1.
- SOFT_HOLD_CYCLES, 16, core reset width for a soft reset; must be >= 1.

Ports:
- clock, input, 1, PLL output clock; the only clock.
- reset, input, 1, synchronous, active-high master reset.
- pll_locked, input, 1, PLL lock flag; asynchronous to clock.
- soft_reset_req, input, 1, soft reset request from the CPU, sampled only in RUN.
- periph_reset, output, 1, active-high reset for peripherals and bus.
- core_reset, output, 1, active-high reset for the softcore.
- ready, output, 1, high when the system is fully out of reset.

Behaviour:
- Single clock; reset is synchronous and active-high. All flops update on the rising edge of clock.
- Lock synchronizer: SYNC_STAGES-deep flop chain, cleared by reset; its last stage is lock_sync.
- Counter: one shared counter cnt, width $clog2(max(LOCK_STABLE_CYCLES, CORE_DELAY_CYCLES, SOFT_HOLD_CYCLES)+1). It is zeroed on every state change and never wraps.
- Outputs are registered decodes of the state register:
  - periph_reset = 1 in RESET, WAIT_LOCK, STABLE.
  - core_reset = 1 in every state except RUN.
  - ready = 1 only in RUN.
- Reset values: state = RESET, cnt = 0, sync chain = 0, periph_reset = 1, core_reset = 1, ready = 0.
- States and transitions:
  - RESET: unconditionally -> WAIT_LOCK on the next edge after reset deasserts.
  - WAIT_LOCK: lock_sync = 1 -> STABLE (cnt = 0).
  - STABLE: lock_sync = 0 -> WAIT_LOCK. Else if cnt == LOCK_STABLE_CYCLES-1 -> PERIPH. Else cnt++.
  - PERIPH: cnt == CORE_DELAY_CYCLES-1 -> RUN. Else cnt++.
  - RUN: soft_reset_req = 1 -> SOFT.
  - SOFT: cnt == SOFT_HOLD_CYCLES-1 -> RUN. Else cnt++. soft_reset_req is ignored while in SOFT.
- Lock loss: in STABLE, PERIPH, RUN or SOFT, lock_sync = 0 -> WAIT_LOCK. Both resets are asserted from that edge.
- Priority: reset > lock loss > counter terminal > soft_reset_req.
- Reset asserted mid-sequence: next edge returns to RESET state with the reset values above; any partial count is discarded.
- Latency: let edge k be the last edge at which reset is sampled high, with pll_locked held high.
  - periph_reset falls at edge k+SYNC_STAGES+LOCK_STABLE_CYCLES+1.
  - core_reset falls and ready rises CORE_DELAY_CYCLES edges later.
- Lock glitch during STABLE: the stability count restarts from zero after re-lock.
- Soft reset: soft_reset_req sampled high in RUN at edge j. core_reset = 1 and ready = 0 from edge j; RUN resumes at edge j+SOFT_HOLD_CYCLES. periph_reset is unaffected.
- No combinational path from any input to any output.

Decomposition:
- Shared package rst_pkg holds:
  - state typedef (RESET, WAIT_LOCK, STABLE, PERIPH, RUN, SOFT), 3-bit encoding;
  - default cycle constants for the parameters.
- One sub-module: sync_bit, an N-stage single-bit synchronizer with synchronous clear. It is reused elsewhere for button and UART inputs.

Test Plan:
- Cold start, SYNC_STAGES=2, LOCK_STABLE_CYCLES=8, CORE_DELAY_CYCLES=4, pll_locked=1 throughout; reset released after edge 0.
  - periph_reset falls at edge 11.
  - core_reset falls and ready rises at edge 15.
  - Both resets are 1 on all earlier edges.
- Lock glitch in STABLE: pll_locked low for 1 cycle, 5 cycles into STABLE.
  - Count restarts.
  - periph_reset release is delayed by the lost progress plus resync latency; exact edge checked against the model.
- Lock loss in RUN: pll_locked drops.
  - periph_reset, core_reset = 1 and ready = 0 exactly SYNC_STAGES+1 edges after the drop.
  - Full release sequence repeats after re-lock.
- Soft reset, SOFT_HOLD_CYCLES=4: 1-cycle soft_reset_req in RUN.
  - core_reset high for exactly 4 cycles; periph_reset stays 0.
  - A second request during SOFT is ignored, so there is no extension.
- Reset asserted while in PERIPH with cnt=2: the next edge shows all outputs at reset values, and the sequence restarts from RESET.
- pll_locked=0 forever: all resets stay asserted and ready=0 for 10000 cycles.
